mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-to-1 single-bit mux channel among 8 requesters.
- Drives the 3-bit mux select and a one-hot grant vector.
- Bounds each ownership to MAX_HOLD cycles, so no requester can starve the others.
- Sits between requester agents and the shared mux in the processor datapath.

---
 rtl/mux8_rr_arbiter.sv | 99 +++++++++
 tb/tb_mux8_rr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux channel among 8 requesters.
// Each ownership is bounded to MAX_HOLD cycles. All outputs are registered.
module mux8_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned HOLD_W   = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [7:0]        Req,
   output logic [7:0]        Grant,
   output logic [2:0]        Sel,
   output logic              Valid,
   output logic [HOLD_W-1:0] HoldCnt
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   logic [2:0] last;

   logic [2:0] ptr_c;
   logic [2:0] pick_c;
   logic       pick_vld_c;
   logic       release_c;

   // Owner gives up the mux when it stops requesting or its hold budget is spent
   always_comb begin
      release_c = 1'b0;
      if (state == GRANT) begin
         release_c = !Req[Sel] || (HoldCnt == HOLD_W'(MAX_HOLD));
      end
   end

   // Round-robin pick: scan from one past the pointer, wrapping; in GRANT the
   // pointer is the releasing owner, so it becomes the last candidate
   always_comb begin : pick_blk
      logic [2:0] idx;
      idx        = 3'd0;
      pick_c     = 3'd0;
      pick_vld_c = 1'b0;
      ptr_c      = (state == GRANT) ? Sel : last;
      for (int k = 1; k <= 8; k++) begin
         idx = ptr_c + 3'(k);
         if (!pick_vld_c && Req[idx]) begin
            pick_vld_c = 1'b1;
            pick_c     = idx;
         end
      end
   end

   // Arbiter state and registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         last    <= 3'd7;
         Grant   <= 8'd0;
         Sel     <= 3'd0;
         Valid   <= 1'b0;
         HoldCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld_c) begin
                  state   <= GRANT;
                  Grant   <= 8'(1) << pick_c;
                  Sel     <= pick_c;
                  Valid   <= 1'b1;
                  HoldCnt <= HOLD_W'(1);
               end
            end
            GRANT: begin
               if (release_c) begin
                  last <= Sel;
                  if (pick_vld_c) begin
                     Grant   <= 8'(1) << pick_c;
                     Sel     <= pick_c;
                     Valid   <= 1'b1;
                     HoldCnt <= HOLD_W'(1);
                  end else begin
                     state   <= IDLE;
                     Grant   <= 8'd0;
                     Valid   <= 1'b0;
                     HoldCnt <= '0;
                  end
               end else begin
                  HoldCnt <= HoldCnt + HOLD_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: one instance with MAX_HOLD=4 and one
// with MAX_HOLD=1 share clock, reset and request inputs.
module tb_mux8_rr_arbiter;

   typedef struct {
      int         cyc;
      logic [7:0] g;
      logic [2:0] s;
      logic       v;
      logic [7:0] h;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [7:0] req;

   logic [7:0] g4, g1;
   logic [2:0] s4, s1;
   logic       v4, v1;
   logic [7:0] h4, h1;

   exp_t q4[$];
   exp_t q1[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;
   int w4[8];
   int w1[8];

   mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u4 (
      .Clk(clk), .Reset(reset), .Req(req),
      .Grant(g4), .Sel(s4), .Valid(v4), .HoldCnt(h4)
   );

   mux8_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(8)) u1 (
      .Clk(clk), .Reset(reset), .Req(req),
      .Grant(g1), .Sel(s1), .Valid(v1), .HoldCnt(h1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic note(input bit ok, input string name, input string detail);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
      end
   endtask

   function automatic bit inv_ok(input logic [7:0] g, input logic [2:0] s,
                                 input logic v, input logic [7:0] h, input int mh);
      bit ok;
      ok = ((g & (g - 8'd1)) == 8'd0);
      ok = ok && (v == (g != 8'd0));
      ok = ok && (!v || g[s]);
      ok = ok && ((h == 8'd0) == !v);
      ok = ok && (int'(h) <= mh);
      return ok;
   endfunction

   // Monitor: scoreboard pops, invariants and wait bounds on every cycle
   always @(negedge clk) begin
      exp_t e;
      int   mx4, mx1;
      if (mon_en) begin
         if (q4.size() != 0 && q4[0].cyc <= cyc) begin
            e = q4.pop_front();
            note(e.cyc == cyc && g4 == e.g && s4 == e.s && v4 == e.v && h4 == e.h, "dir_mh4",
                 $sformatf("got cyc=%0d g=%h s=%0d v=%0d h=%0d, want cyc=%0d g=%h s=%0d v=%0d h=%0d",
                           cyc, g4, s4, v4, h4, e.cyc, e.g, e.s, e.v, e.h));
         end
         if (q1.size() != 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            note(e.cyc == cyc && g1 == e.g && s1 == e.s && v1 == e.v && h1 == e.h, "dir_mh1",
                 $sformatf("got cyc=%0d g=%h s=%0d v=%0d h=%0d, want cyc=%0d g=%h s=%0d v=%0d h=%0d",
                           cyc, g1, s1, v1, h1, e.cyc, e.g, e.s, e.v, e.h));
         end
         note(inv_ok(g4, s4, v4, h4, 4), "inv_mh4",
              $sformatf("g=%h s=%0d v=%0d h=%0d breaks invariants", g4, s4, v4, h4));
         note(inv_ok(g1, s1, v1, h1, 1), "inv_mh1",
              $sformatf("g=%h s=%0d v=%0d h=%0d breaks invariants", g1, s1, v1, h1));
         mx4 = 0;
         mx1 = 0;
         for (int i = 0; i < 8; i++) begin
            w4[i] = (reset || !req[i] || g4[i]) ? 0 : w4[i] + 1;
            w1[i] = (reset || !req[i] || g1[i]) ? 0 : w1[i] + 1;
            if (w4[i] > mx4) mx4 = w4[i];
            if (w1[i] > mx1) mx1 = w1[i];
         end
         note(mx4 <= 7 * 4 + 1, "wait_mh4", $sformatf("max wait %0d, limit %0d", mx4, 29));
         note(mx1 <= 7 * 1 + 1, "wait_mh1", $sformatf("max wait %0d, limit %0d", mx1, 8));
      end
   end

   // Drive inputs for the next edge and queue the MAX_HOLD=4 response after it
   task automatic drive(input logic r, input logic [7:0] rq, input logic [7:0] g,
                        input logic [2:0] s, input logic v, input logic [7:0] h);
      @(posedge clk);
      #1;
      reset = r;
      req   = rq;
      q4.push_back('{cyc + 1, g, s, v, h});
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) begin
         w4[i] = 0;
         w1[i] = 0;
      end
      reset = 1'b1;
      req   = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Reset with all requesting, then full rotation 0..7..0
      drive(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 8'd0);
      q1.push_back('{cyc + 1, 8'h00, 3'd0, 1'b0, 8'd0});
      for (int o = 0; o < 9; o++) begin
         for (int h = 1; h <= 4; h++) begin
            drive(1'b0, 8'hFF, 8'(1) << (o % 8), 3'(o % 8), 1'b1, 8'(h));
            n = o * 4 + h - 1;
            q1.push_back('{cyc + 1, 8'(1) << (n % 8), 3'(n % 8), 1'b1, 8'd1});
         end
      end

      // Lone requester 4: re-granted with HoldCnt restarting
      drive(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
      drive(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd1);
      drive(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd2);
      drive(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd3);
      drive(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd4);
      drive(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd1);
      drive(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd2);

      // Owner 2 drops early with 7 and 0 waiting
      drive(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
      drive(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 8'd1);
      drive(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 8'd2);
      drive(1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 8'd1);
      drive(1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 8'd2);
      drive(1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 8'd3);
      drive(1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 8'd4);
      drive(1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 8'd1);

      // All requests vanish under owner 5: idle keeps Sel, pointer stays at 5
      drive(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
      drive(1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 8'd1);
      drive(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 8'd0);
      drive(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 8'd0);
      drive(1'b0, 8'h21, 8'h01, 3'd0, 1'b1, 8'd1);
      drive(1'b0, 8'h21, 8'h01, 3'd0, 1'b1, 8'd2);

      // Reset mid-grant of owner 3, then 2 wins from the reset pointer
      drive(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
      drive(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 8'd1);
      drive(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 8'd2);
      drive(1'b1, 8'h0C, 8'h00, 3'd0, 1'b0, 8'd0);
      drive(1'b0, 8'h0C, 8'h04, 3'd2, 1'b1, 8'd1);
      drive(1'b0, 8'h0C, 8'h04, 3'd2, 1'b1, 8'd2);

      // Slowly toggling random requests; monitor checks invariants and waits
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         end
      end

      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      note(q4.size() == 0, "drain_mh4", $sformatf("%0d entries left, want 0", q4.size()));
      note(q1.size() == 0, "drain_mh1", $sformatf("%0d entries left, want 0", q1.size()));
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
